// File: rtl/ex_mul_sequencer_if.sv
// EX-stage multiply request/result bundle between the EX decode and the
// shift-add multiplier sequencer.
//
// Handshake: start is a level request held high while the multiply sits in
// EX. It is accepted in any IDLE cycle where start=1 and flush=0. reg_lock
// acts as the inverse of "ready to advance": while it is high, EX and every
// upstream stage hold. done pulses for exactly one cycle with reg_lock low,
// so the EX/MEM register captures prod_hi/prod_lo on that same edge.
// fsm_state exposes the sequencer state (0=IDLE, 1=RUN, 2=DONE) for observation.
interface ex_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             reg_lock;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [1:0]       fsm_state;

    modport master (
        output start, is_signed, flush, op_a, op_b,
        input  reg_lock, busy, done, prod_hi, prod_lo, fsm_state
    );

    modport slave (
        input  start, is_signed, flush, op_a, op_b,
        output reg_lock, busy, done, prod_hi, prod_lo, fsm_state
    );
endinterface

// File: rtl/ex_mul_sequencer.sv
// Iterative 1-bit-per-cycle shift-add multiplier for the EX stage.
// Signed multiplies run on operand magnitudes, and the product is negated at
// the end. The pipeline is frozen through reg_lock while the sequence runs.
module ex_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    ex_mul_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]   acc;
    logic            neg;
    logic [PW-1:0]   prod;

    logic            accept;
    logic            step;
    logic            finish;
    logic            lock;
    logic            busy_c;
    logic            done_c;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    prod_final;

    // Operand magnitudes. These are unsigned WIDTH-bit values, so -2^(WIDTH-1)
    // maps to 2^(WIDTH-1) without overflow.
    assign mag_a = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    assign mag_b = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

    // Partial sum for this iteration and the sign-corrected final product.
    assign acc_sum    = acc + (mplier[0] ? mcand : {PW{1'b0}});
    assign prod_final = neg ? -acc_sum : acc_sum;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and control decode. A flush in RUN drops reg_lock in that same cycle.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        lock    = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept  = 1'b1;
                    lock    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (bus.flush) begin
                    state_n = IDLE;
                end else begin
                    lock = 1'b1;
                    step = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        finish  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath. Operands are latched on accept, and one multiplier bit is consumed per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            prod   <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
        end else if (step) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (finish) begin
                prod <= prod_final;
            end
        end
    end

    assign bus.reg_lock  = lock;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.prod_hi   = prod[PW-1:WIDTH];
    assign bus.prod_lo   = prod[WIDTH-1:0];
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Bench for ex_mul_sequencer. It compares against an arithmetic reference
// product and checks the cycle timing of reg_lock and done.
module tb_ex_mul_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_prod;

    ex_mul_sequencer_if #(.WIDTH(W)) bus();

    ex_mul_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Reference product, computed from plain full-width arithmetic.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Driver: present a multiply at the current cycle. The task returns the
    // reg_lock-high cycle count before done, the cycle index of done, and the product.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit keep, output int lock_cnt, output int done_cyc,
                          output logic lock_at_done, output logic [2*W-1:0] prod);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.is_signed = s;
        bus.start     = 1'b1;
        lock_cnt      = 0;
        done_cyc      = 0;
        lock_at_done  = 1'b1;
        prod          = '0;
        for (int c = 1; c <= W + 6; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cyc     = c;
                lock_at_done = bus.reg_lock;
                prod         = {bus.prod_hi, bus.prod_lo};
            end else if (bus.reg_lock === 1'b1) begin
                lock_cnt++;
            end
            @(posedge clk);
            #1;
            if (c == 1) begin
                bus.op_a      = $urandom;
                bus.op_b      = $urandom;
                bus.is_signed = 1'($urandom_range(0, 1));
            end
            if (done_cyc != 0) break;
        end
        if (!keep) bus.start = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        total++; if ({bus.prod_hi, bus.prod_lo} !== '0) begin bad++; $display("FAIL reset_prod: got %h want 0", {bus.prod_hi, bus.prod_lo}); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.reg_lock !== 1'b0) begin bad++; $display("FAIL reset_lock: got %b want 0", bus.reg_lock); end
        total++; if (bus.fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.fsm_state); end
        last_prod = '0;
    endtask

    task automatic test_unsigned;
        int lc, dc; logic ld; logic [2*W-1:0] p, e;
        exp_q.push_back(64'h00000001_FFFFFFFE);
        do_mul(32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, lc, dc, ld, p);
        e = exp_q.pop_front();
        total++; if (lc !== 33) begin bad++; $display("FAIL unsigned_lock_cycles: got %0d want 33", lc); end
        total++; if (dc !== 34) begin bad++; $display("FAIL unsigned_done_cycle: got %0d want 34", dc); end
        total++; if (p !== e) begin bad++; $display("FAIL unsigned_prod: got %h want %h", p, e); end
        last_prod = e;
    endtask

    task automatic test_signed;
        int lc, dc; logic ld; logic [2*W-1:0] p, e;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
        do_mul(32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b0, lc, dc, ld, p);
        e = exp_q.pop_front();
        total++; if (p !== e) begin bad++; $display("FAIL signed_neg3x7: got %h want %h", p, e); end
        exp_q.push_back(64'h40000000_00000000);
        do_mul(32'h80000000, 32'h80000000, 1'b1, 1'b0, lc, dc, ld, p);
        e = exp_q.pop_front();
        total++; if (p !== e) begin bad++; $display("FAIL signed_minxmin: got %h want %h", p, e); end
        total++; if (dc !== 34) begin bad++; $display("FAIL signed_done_cycle: got %0d want 34", dc); end
        last_prod = e;
    endtask

    task automatic test_random;
        int lc, dc; logic ld; logic [2*W-1:0] p, e;
        logic [W-1:0] a, b; logic s;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i == 0) a = 32'h80000000;
            if (i == 1) b = 32'h0;
            if (i == 2) begin a = 32'h7FFFFFFF; b = 32'h80000000; end
            exp_q.push_back(model(a, b, s));
            do_mul(a, b, s, 1'b0, lc, dc, ld, p);
            e = exp_q.pop_front();
            total++; if (p !== e) begin bad++; $display("FAIL random_prod[%0d] a=%h b=%h s=%b: got %h want %h", i, a, b, s, p, e); end
            total++; if (dc !== 34) begin bad++; $display("FAIL random_done_cycle[%0d]: got %0d want 34", i, dc); end
            last_prod = e;
        end
    endtask

    task automatic test_flush;
        bit seen_done;
        bus.op_a      = $urandom;
        bus.op_b      = $urandom;
        bus.is_signed = 1'b0;
        bus.start     = 1'b1;
        // Advance from the accept cycle to RUN iteration 10.
        repeat (11) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        #1;
        total++; if (bus.reg_lock !== 1'b0) begin bad++; $display("FAIL flush_lock_same_cycle: got %b want 0", bus.reg_lock); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_busy_in_run: got %b want 1", bus.busy); end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        total++; if (bus.fsm_state !== 2'd0) begin bad++; $display("FAIL flush_state: got %0d want 0", bus.fsm_state); end
        total++; if (bus.reg_lock !== 1'b0) begin bad++; $display("FAIL flush_lock_after: got %b want 0", bus.reg_lock); end
        seen_done = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        total++; if (seen_done) begin bad++; $display("FAIL flush_no_done: got done pulse want none"); end
        total++; if ({bus.prod_hi, bus.prod_lo} !== last_prod) begin bad++; $display("FAIL flush_prod_kept: got %h want %h", {bus.prod_hi, bus.prod_lo}, last_prod); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lc, dc; logic ld; logic [2*W-1:0] p, e;
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        exp_q.push_back(model(a, b, 1'b1));
        do_mul(a, b, 1'b1, 1'b1, lc, dc, ld, p);
        e = exp_q.pop_front();
        total++; if (ld !== 1'b0) begin bad++; $display("FAIL b2b_no_accept_in_done: got reg_lock=%b want 0", ld); end
        total++; if (p !== e) begin bad++; $display("FAIL b2b_first_prod: got %h want %h", p, e); end
        a = $urandom; b = $urandom;
        bus.op_a = a; bus.op_b = b; bus.is_signed = 1'b0;
        #1;
        total++; if (bus.fsm_state !== 2'd0 || bus.reg_lock !== 1'b1) begin bad++; $display("FAIL b2b_accept_idle: got state=%0d lock=%b want 0/1", bus.fsm_state, bus.reg_lock); end
        exp_q.push_back(model(a, b, 1'b0));
        do_mul(a, b, 1'b0, 1'b0, lc, dc, ld, p);
        e = exp_q.pop_front();
        total++; if (dc !== 34) begin bad++; $display("FAIL b2b_spacing: got %0d want 34", dc); end
        total++; if (p !== e) begin bad++; $display("FAIL b2b_second_prod: got %h want %h", p, e); end
        last_prod = e;
    endtask

    task automatic test_reset_mid_run;
        int lc, dc; logic ld; logic [2*W-1:0] p, e;
        logic [W-1:0] a, b;
        bus.op_a = $urandom; bus.op_b = $urandom; bus.is_signed = 1'b1;
        bus.start = 1'b1;
        // Advance from the accept cycle to RUN iteration 5.
        repeat (6) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        total++; if (bus.fsm_state !== 2'd0) begin bad++; $display("FAIL rst_run_state: got %0d want 0", bus.fsm_state); end
        total++; if ({bus.prod_hi, bus.prod_lo} !== '0) begin bad++; $display("FAIL rst_run_prod: got %h want 0", {bus.prod_hi, bus.prod_lo}); end
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rst_run_flags: got done=%b busy=%b want 0/0", bus.done, bus.busy); end
        total++; if (bus.reg_lock !== 1'b1) begin bad++; $display("FAIL rst_run_lock_follows_start: got %b want 1", bus.reg_lock); end
        a = $urandom; b = $urandom;
        exp_q.push_back(model(a, b, 1'b1));
        do_mul(a, b, 1'b1, 1'b0, lc, dc, ld, p);
        e = exp_q.pop_front();
        total++; if (lc !== 33) begin bad++; $display("FAIL rst_run_lock_cycles: got %0d want 33", lc); end
        total++; if (dc !== 34) begin bad++; $display("FAIL rst_run_done_cycle: got %0d want 34", dc); end
        total++; if (p !== e) begin bad++; $display("FAIL rst_run_prod_after: got %h want %h", p, e); end
        last_prod = e;
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_mul_sequencer.md
Name: ex_mul_sequencer

Overview:
- Iterative shift-add multiplier controller for the execute stage.
- Accepts a multiply request from the EX stage and holds that stage, and everything upstream of it, frozen by driving the stage-hold line `reg_lock` for the duration of the operation.
- Runs a 1-bit-per-cycle sequence over the latched operands, then presents a 64-bit product for one cycle so the EX result mux captures it into the EX/MEM register.
- Serves DLX `mult`/`multu` without lengthening the single-cycle ALU path.

Parameters:
- WIDTH, 32, operand width in bits. The product is 2*WIDTH. The iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  Pipeline clock. All state changes on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- start  in  1  Multiply request from the EX decode. Level signal, held high while the instruction sits in EX.
- is_signed  in  1  1 = `mult` (two's complement), 0 = `multu`. Sampled with `start`.
- flush  in  1  Pipeline flush. Aborts any operation in progress.
- op_a  in  WIDTH  Multiplicand (busA). Sampled on the accept cycle.
- op_b  in  WIDTH  Multiplier (busB). Sampled on the accept cycle.
- reg_lock  out  1  Stall to the EX pipeline register and upstream stages.
- busy  out  1  High in RUN state.
- done  out  1  One-cycle pulse: product valid.
- prod_hi  out  WIDTH  Upper half of the product.
- prod_lo  out  WIDTH  Lower half of the product.

Behaviour:
- States:
  - IDLE: waiting for a request.
  - RUN: iterating, one multiplier bit per cycle.
  - DONE: product presented, for exactly one cycle.
- Reset (synchronous, wins over every other input):
  - State = IDLE; counter = 0.
  - prod_hi = prod_lo = 0; done = 0; busy = 0.
  - reg_lock = 0, except that in IDLE it follows `start` combinationally (see reg_lock rule below).
- IDLE:
  - If start=1 and flush=0, accept the request:
    - Latch |op_a| and |op_b|. Magnitudes apply only when is_signed=1; otherwise latch raw values.
    - Latch neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
    - Clear the accumulator and counter = 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If the current multiplier LSB = 1, add the shifted multiplicand into the 2*WIDTH accumulator.
  - Shift the multiplier right and the multiplicand left; counter++.
  - When counter = WIDTH-1 is completing, the final accumulator, negated in two's complement if neg=1 and truncated to 2*WIDTH, is registered into prod_hi/prod_lo, and the state goes to DONE.
- DONE:
  - done=1 for this single cycle; next state IDLE unconditionally.
  - start is ignored here: the same instruction is still in EX this cycle.
- Product width rule:
  - Magnitudes are treated as unsigned WIDTH bits, so the most-negative operand magnitude 2^(WIDTH-1) is handled correctly.
  - The result is exact modulo 2^(2*WIDTH).
- reg_lock (combinational):
  - (state==IDLE & start & ~flush) | (state==RUN).
  - Low in DONE, so the EX register advances and captures the product on that edge.
- Latency:
  - start accepted at edge-cycle T.
  - reg_lock high in cycles T..T+WIDTH; done high in cycle T+WIDTH+1.
  - Total EX occupancy = WIDTH+2 cycles.
- prod_hi/prod_lo hold their value until the next completion or reset. They are not cleared on accept.
- flush:
  - In RUN: return to IDLE next edge. No done pulse; prod_* unchanged; reg_lock drops in the same cycle flush is seen.
  - In IDLE: blocks the accept.
  - In DONE: no effect; done still pulses.
- Operands changing during RUN have no effect, because they are latched.
- The block never accepts a new request in the cycle immediately after DONE unless start is high in IDLE. Back-to-back multiplies are therefore separated by exactly one DONE cycle.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, start=0.
  - Required: prod_hi=prod_lo=0, done=busy=reg_lock=0.
- Unsigned multiply:
  - Stimulus: multu 0xFFFFFFFF × 0x00000002.
  - Required: reg_lock high for 33 cycles; done in cycle 34; prod_hi=0x00000001, prod_lo=0xFFFFFFFE.
- Signed multiply:
  - Stimulus: mult 0xFFFFFFFD (-3) × 0x00000007.
  - Required: prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFEB.
  - Stimulus: mult 0x80000000 × 0x80000000.
  - Required: prod_hi=0x40000000, prod_lo=0x00000000.
- Flush mid-operation:
  - Stimulus: flush=1 at RUN iteration 10.
  - Required: state IDLE next cycle; reg_lock=0; no done pulse; prod_* keep the previous result.
- Held start and back-to-back:
  - Stimulus: start held high across DONE.
  - Required: no second accept during DONE.
  - Stimulus: a second mult presented in the next cycle (IDLE).
  - Required: accepted, done exactly 34 cycles after the first done.
- Reset mid-RUN:
  - Stimulus: reset asserted at iteration 5 with start=1.
  - Required: IDLE, all outputs zero, reg_lock equals start in the next cycle after reset deasserts. A new operation then runs the full 34 cycles.
